// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake bus: the MEM stage (master) presents one instruction
// per cycle, and the writeback stage (slave) answers with in_ready.
interface wb_stage_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_wb_sel;
  logic [31:0]           in_alu_out;
  logic [31:0]           in_read_data;
  logic [31:0]           in_pc_plus4;
  logic [15:0]           in_imm;
  logic [2:0]            in_load_type;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_write_reg;

  modport master (
    output in_valid, in_wb_sel, in_alu_out, in_read_data, in_pc_plus4,
           in_imm, in_load_type, in_reg_write, in_write_reg,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_wb_sel, in_alu_out, in_read_data, in_pc_plus4,
           in_imm, in_load_type, in_reg_write, in_write_reg,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with a four-way writeback select, big-endian
// sub-word load alignment, misaligned-load detection and a retire counter.
module wb_stage #(
  parameter int REG_ADDR_W        = 5,
  parameter int CNT_W             = 32,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  wb_stage_if.slave             mem,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [31:0]           wb_write_data,
  output logic                  wb_fault,
  output logic [31:0]           wb_fault_addr,
  output logic [CNT_W-1:0]      retired_cnt
);

  logic [1:0]  offset;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;
  logic [31:0] next_data;
  logic        word_load;
  logic        half_load;
  logic        misaligned;
  logic        capture;
  logic        zero_dest;
  logic        next_reg_write;

  assign mem.in_ready = !stall;
  assign capture      = mem.in_valid && !stall && !flush;
  assign offset       = mem.in_alu_out[1:0];

  always_comb begin
    half_sel  = offset[1] ? mem.in_read_data[15:0] : mem.in_read_data[31:16];
    byte_sel  = mem.in_read_data[31:24];
    load_data = mem.in_read_data;
    word_load = 1'b0;
    half_load = 1'b0;
    next_data = mem.in_alu_out;

    // Big-endian: offset 0 addresses the most significant byte of the word.
    case (offset)
      2'd1:    byte_sel = mem.in_read_data[23:16];
      2'd2:    byte_sel = mem.in_read_data[15:8];
      2'd3:    byte_sel = mem.in_read_data[7:0];
      default: byte_sel = mem.in_read_data[31:24];
    endcase

    case (mem.in_load_type)
      3'd1: begin
        half_load = 1'b1;
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      3'd2: begin
        half_load = 1'b1;
        load_data = {16'h0000, half_sel};
      end
      3'd3:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_data = {24'h000000, byte_sel};
      default: word_load = 1'b1;
    endcase

    misaligned = (mem.in_wb_sel == 2'd1) &&
                 ((word_load && (offset != 2'd0)) || (half_load && offset[0]));

    case (mem.in_wb_sel)
      2'd1:    next_data = load_data;
      2'd2:    next_data = mem.in_pc_plus4;
      2'd3:    next_data = {mem.in_imm, 16'h0000};
      default: next_data = mem.in_alu_out;
    endcase
  end

  assign zero_dest      = ZERO_REG_SUPPRESS && (mem.in_write_reg == '0);
  assign next_reg_write = mem.in_reg_write && !misaligned && !zero_dest;

  // Stall freezes everything; an unstalled bubble or flush only drops the
  // valid/write/fault flags so the payload keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
      wb_fault      <= 1'b0;
      wb_fault_addr <= '0;
      retired_cnt   <= '0;
    end else if (!stall) begin
      if (capture) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= next_reg_write;
        wb_write_reg  <= mem.in_write_reg;
        wb_write_data <= next_data;
        wb_fault      <= misaligned;
        if (misaligned) begin
          wb_fault_addr <= mem.in_alu_out;
        end else begin
          retired_cnt <= retired_cnt + CNT_W'(1);
        end
      end else begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
        wb_fault     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomised and directed bench for wb_stage, checked every cycle against a
// behavioural model of the writeback rules; a 4-bit-counter copy covers wrap.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic check_en = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  wb_stage_if #(.REG_ADDR_W(5)) mif ();
  wb_stage_if #(.REG_ADDR_W(5)) mif4 ();

  logic        wb_valid, wb_reg_write, wb_fault;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data, wb_fault_addr, retired_cnt;

  logic        d4_valid, d4_reg_write, d4_fault;
  logic [4:0]  d4_write_reg;
  logic [31:0] d4_write_data, d4_fault_addr;
  logic [3:0]  d4_cnt;

  assign mif4.in_valid     = mif.in_valid;
  assign mif4.in_wb_sel    = mif.in_wb_sel;
  assign mif4.in_alu_out   = mif.in_alu_out;
  assign mif4.in_read_data = mif.in_read_data;
  assign mif4.in_pc_plus4  = mif.in_pc_plus4;
  assign mif4.in_imm       = mif.in_imm;
  assign mif4.in_load_type = mif.in_load_type;
  assign mif4.in_reg_write = mif.in_reg_write;
  assign mif4.in_write_reg = mif.in_write_reg;

  wb_stage #(.REG_ADDR_W(5), .CNT_W(32), .ZERO_REG_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem(mif),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .wb_fault(wb_fault), .wb_fault_addr(wb_fault_addr),
    .retired_cnt(retired_cnt)
  );

  wb_stage #(.REG_ADDR_W(5), .CNT_W(4), .ZERO_REG_SUPPRESS(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem(mif4),
    .wb_valid(d4_valid), .wb_reg_write(d4_reg_write), .wb_write_reg(d4_write_reg),
    .wb_write_data(d4_write_data), .wb_fault(d4_fault), .wb_fault_addr(d4_fault_addr),
    .retired_cnt(d4_cnt)
  );

  always #5 clk = ~clk;

  // Reference state, advanced on each active edge from the sampled inputs.
  logic        m_valid = 1'b0, m_reg_write = 1'b0, m_fault = 1'b0;
  logic [4:0]  m_write_reg = '0;
  logic [31:0] m_data = '0, m_fault_addr = '0, m_cnt = '0;
  int          m_cnt4 = 0;

  function automatic logic [31:0] modelData(input logic [1:0] sel, input logic [31:0] alu,
                                            input logic [31:0] rd, input logic [31:0] pc,
                                            input logic [15:0] imm, input logic [2:0] lt);
    int off;
    logic [31:0] v;
    off = int'(alu % 32'd4);
    v = rd;
    if (sel == 2'd0) v = alu;
    else if (sel == 2'd2) v = pc;
    else if (sel == 2'd3) v = {imm, 16'h0000};
    else if (lt == 3'd1 || lt == 3'd2) begin
      v = (rd >> (16 * (1 - off / 2))) & 32'h0000FFFF;
      if (lt == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    end else if (lt == 3'd3 || lt == 3'd4) begin
      v = (rd >> (8 * (3 - off))) & 32'h000000FF;
      if (lt == 3'd3 && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic modelBad(input logic [1:0] sel, input logic [31:0] alu,
                                    input logic [2:0] lt);
    int off;
    off = int'(alu % 32'd4);
    if (sel != 2'd1) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return (off % 2) != 0;
    if (lt == 3'd3 || lt == 3'd4) return 1'b0;
    return off != 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic bad;
    if (!rst_n) begin
      m_valid = 1'b0; m_reg_write = 1'b0; m_fault = 1'b0; m_write_reg = '0;
      m_data = '0; m_fault_addr = '0; m_cnt = '0; m_cnt4 = 0;
    end else if (!stall) begin
      if (mif.in_valid && !flush) begin
        bad = modelBad(mif.in_wb_sel, mif.in_alu_out, mif.in_load_type);
        m_valid     = 1'b1;
        m_fault     = bad;
        m_write_reg = mif.in_write_reg;
        m_reg_write = mif.in_reg_write && !bad && (mif.in_write_reg != 5'd0);
        m_data      = modelData(mif.in_wb_sel, mif.in_alu_out, mif.in_read_data,
                                mif.in_pc_plus4, mif.in_imm, mif.in_load_type);
        if (bad) m_fault_addr = mif.in_alu_out;
        else begin
          m_cnt  = m_cnt + 32'd1;
          m_cnt4 = (m_cnt4 + 1) % 16;
        end
      end else begin
        m_valid = 1'b0; m_reg_write = 1'b0; m_fault = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready", 32'(mif.in_ready), 32'(!stall));
      checkOutput("wb_valid", 32'(wb_valid), 32'(m_valid));
      checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(m_reg_write));
      checkOutput("wb_fault", 32'(wb_fault), 32'(m_fault));
      checkOutput("wb_fault_addr", wb_fault_addr, m_fault_addr);
      checkOutput("retired_cnt", retired_cnt, m_cnt);
      checkOutput("retired_cnt4", 32'(d4_cnt), 32'(m_cnt4));
      if (m_valid) checkOutput("wb_write_reg", 32'(wb_write_reg), 32'(m_write_reg));
      if (m_valid && !m_fault) checkOutput("wb_write_data", wb_write_data, m_data);
    end
  end

  // Drives one cycle of inputs, then returns just after the capturing edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic v,
                               input logic [1:0] sel, input logic [31:0] alu,
                               input logic [31:0] rd, input logic [31:0] pc,
                               input logic [15:0] imm, input logic [2:0] lt,
                               input logic rw, input logic [4:0] wr);
    stall = st;
    flush = fl;
    mif.in_valid = v;
    mif.in_wb_sel = sel;
    mif.in_alu_out = alu;
    mif.in_read_data = rd;
    mif.in_pc_plus4 = pc;
    mif.in_imm = imm;
    mif.in_load_type = lt;
    mif.in_reg_write = rw;
    mif.in_write_reg = wr;
    @(posedge clk);
    #2;
  endtask

  task automatic randomStep(input logic st, input logic fl);
    logic [4:0] wr;
    wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    applyStimulus(st, fl, $urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), $urandom,
                  $urandom, $urandom, 16'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), wr);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, '0, 3'd0, 1'b0, 5'd0);
    rst_n = 1'b0;
    check_en = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("reset_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_cnt", retired_cnt, 32'd0);
    checkOutput("reset_data", wb_write_data, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1000, 32'hDEADBEEF, '0, '0, 3'd0, 1'b1, 5'd8);
    checkOutput("lw_data", wb_write_data, 32'hDEADBEEF);
    checkOutput("lw_reg_write", 32'(wb_reg_write), 32'd1);
    checkOutput("lw_cnt", retired_cnt, 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1000, 32'h80FF7F01, '0, '0, 3'd3, 1'b1, 5'd9);
    checkOutput("lb_off0", wb_write_data, 32'hFFFFFF80);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1001, 32'h80FF7F01, '0, '0, 3'd4, 1'b1, 5'd9);
    checkOutput("lbu_off1", wb_write_data, 32'h000000FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1002, 32'h80FF7F01, '0, '0, 3'd3, 1'b1, 5'd9);
    checkOutput("lb_off2", wb_write_data, 32'h0000007F);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1002, 32'h80FF7F01, '0, '0, 3'd1, 1'b1, 5'd9);
    checkOutput("lh_off2", wb_write_data, 32'h00007F01);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1000, 32'h80FF7F01, '0, '0, 3'd2, 1'b1, 5'd9);
    checkOutput("lhu_off0", wb_write_data, 32'h000080FF);

    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 32'h5, '0, 32'h00400008, '0, 3'd0, 1'b1, 5'd31);
    checkOutput("link_data", wb_write_data, 32'h00400008);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h5, '0, '0, 16'h1234, 3'd0, 1'b1, 5'd4);
    checkOutput("lui_data", wb_write_data, 32'h12340000);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h77, '0, '0, '0, 3'd0, 1'b1, 5'd0);
    checkOutput("r0_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("r0_cnt", retired_cnt, 32'd9);

    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h1002, 32'h12345678, '0, '0, 3'd0, 1'b1, 5'd3);
    checkOutput("mis_fault", 32'(wb_fault), 32'd1);
    checkOutput("mis_addr", wb_fault_addr, 32'h1002);
    checkOutput("mis_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("mis_valid", 32'(wb_valid), 32'd1);
    checkOutput("mis_cnt", retired_cnt, 32'd9);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h55, '0, '0, '0, 3'd0, 1'b1, 5'd2);
    checkOutput("clear_fault", 32'(wb_fault), 32'd0);
    checkOutput("clear_addr_hold", wb_fault_addr, 32'h1002);
    checkOutput("clear_cnt", retired_cnt, 32'd10);

    for (int i = 0; i < 3; i++) begin
      randomStep(1'b1, 1'b0);
      checkOutput("stall_data", wb_write_data, 32'h55);
      checkOutput("stall_cnt", retired_cnt, 32'd10);
    end
    randomStep(1'b1, 1'b1);
    checkOutput("stallflush_valid", 32'(wb_valid), 32'd1);
    checkOutput("stallflush_cnt", retired_cnt, 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 32'h99, '0, '0, '0, 3'd0, 1'b1, 5'd2);
    checkOutput("flush_valid", 32'(wb_valid), 32'd0);
    checkOutput("flush_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("flush_cnt", retired_cnt, 32'd10);

    for (int i = 0; i < 400; i++) begin
      randomStep($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
    end

    stall = 1'b1;
    mif.in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(wb_valid), 32'd0);
    checkOutput("async_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("async_write_reg", 32'(wb_write_reg), 32'd0);
    checkOutput("async_data", wb_write_data, 32'd0);
    checkOutput("async_fault", 32'(wb_fault), 32'd0);
    checkOutput("async_fault_addr", wb_fault_addr, 32'd0);
    checkOutput("async_cnt", retired_cnt, 32'd0);
    checkOutput("async_cnt4", 32'(d4_cnt), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h10, '0, '0, '0, 3'd0, 1'b1, 5'd1);
    checkOutput("post_reset_cnt", retired_cnt, 32'd1);
    for (int i = 1; i < 17; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'(i), '0, '0, '0, 3'd0, 1'b1, 5'd1);
    end
    checkOutput("wrap_cnt4", 32'(d4_cnt), 32'd1);
    checkOutput("wrap_cnt32", retired_cnt, 32'd17);

    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, '0, 3'd0, 1'b0, 5'd0);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
